// File: rtl/regfile_mp_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp_if
// Description : Read/write/clear bus bundle for the multi-port register file.
// Revision    : 1.0  initial release
// ============================================================================
interface regfile_mp_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2
);
    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic [NRD*AW-1:0]   raddr;
    logic [NRD*XLEN-1:0] rdata;
    logic                wr_en;
    logic [AW-1:0]       waddr;
    logic [XLEN-1:0]     wdata;
    logic                wr_ready;
    logic                clr_req;
    logic                busy;
    logic                clr_done;

    modport master (
        output raddr, wr_en, waddr, wdata, clr_req,
        input  rdata, wr_ready, busy, clr_done
    );

    modport slave (
        input  raddr, wr_en, waddr, wdata, clr_req,
        output rdata, wr_ready, busy, clr_done
    );
endinterface
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp
// Description : Multi-read-port register file with write bypass and a
//               one-register-per-cycle sweep clear.
// Revision    : 1.0  initial release
// ============================================================================
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    regfile_mp_if.slave rf
);
    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [AW-1:0] c_last    = AW'(NREGS - 1);
    localparam logic [AW-1:0] c_prelast = AW'(NREGS - 2);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t              r_state;
    logic [AW-1:0]       r_index;
    logic                r_busy;
    logic                r_clr_done;
    logic [XLEN-1:0]     r_regs [NREGS];

    logic                w_wr_fire;
    logic [AW-1:0]       w_ra;
    logic [NRD*XLEN-1:0] w_rdata;

    assign w_wr_fire = rf.wr_en && !r_busy
                       && (32'(rf.waddr) < NREGS)
                       && !((ZERO_REG != 0) && (rf.waddr == '0));

    assign rf.wr_ready = !r_busy;
    assign rf.busy     = r_busy;
    assign rf.clr_done = r_clr_done;
    assign rf.rdata    = w_rdata;

    // Bypass is naturally suppressed during a sweep because w_wr_fire needs !busy.
    always_comb begin
        w_rdata = '0;
        w_ra    = '0;
        for (int k = 0; k < NRD; k++) begin
            w_ra = rf.raddr[k*AW +: AW];
            if ((ZERO_REG != 0) && (w_ra == '0)) begin
                w_rdata[k*XLEN +: XLEN] = '0;
            end else if (!(32'(w_ra) < NREGS)) begin
                w_rdata[k*XLEN +: XLEN] = '0;
            end else if ((BYPASS != 0) && w_wr_fire && (rf.waddr == w_ra)) begin
                w_rdata[k*XLEN +: XLEN] = rf.wdata;
            end else begin
                w_rdata[k*XLEN +: XLEN] = r_regs[w_ra];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_index    <= '0;
            r_busy     <= 1'b0;
            r_clr_done <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_wr_fire) begin
                        r_regs[rf.waddr] <= rf.wdata;
                    end
                    if (rf.clr_req) begin
                        r_state    <= S_CLEAR;
                        r_index    <= '0;
                        r_busy     <= 1'b1;
                        r_clr_done <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    r_regs[r_index] <= '0;
                    if (r_index == c_last) begin
                        r_state    <= S_IDLE;
                        r_index    <= '0;
                        r_busy     <= 1'b0;
                        r_clr_done <= 1'b0;
                    end else begin
                        r_index    <= r_index + 1'b1;
                        // Raise done so it is visible during the final sweep cycle.
                        r_clr_done <= (r_index == c_prelast);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_mp
// Description : Scoreboard bench for regfile_mp (default, no-bypass, 20-reg).
// Revision    : 1.0  initial release
// ============================================================================
module tb_regfile_mp;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2)) rf    ();
    regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2)) rf_nb ();
    regfile_mp_if #(.XLEN(32), .NREGS(20), .NRD(2)) rf_20 ();

    regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .rf(rf.slave));
    regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .rf(rf_nb.slave));
    regfile_mp #(.XLEN(32), .NREGS(20), .NRD(2), .ZERO_REG(1), .BYPASS(1)) dut_20 (
        .clk(clk), .rst_n(rst_n), .rf(rf_20.slave));

    // d: 0 default, 1 no-bypass, 2 NREGS=20; s: 0 rdata, 1 busy, 2 wr_ready, 3 clr_done
    typedef struct packed {
        logic [1:0]  d;
        logic [1:0]  s;
        logic [1:0]  p;
        logic [31:0] v;
    } exp_t;

    exp_t  q  [$];
    string qn [$];
    int    n_chk  = 0;
    int    n_pass = 0;

    function automatic logic [31:0] sample(input logic [1:0] d, input logic [1:0] s,
                                           input logic [1:0] p);
        logic [63:0] rd;
        logic        bz, wr, cd;
        case (d)
            2'd0:    begin rd = rf.rdata;    bz = rf.busy;    wr = rf.wr_ready;    cd = rf.clr_done;    end
            2'd1:    begin rd = rf_nb.rdata; bz = rf_nb.busy; wr = rf_nb.wr_ready; cd = rf_nb.clr_done; end
            default: begin rd = rf_20.rdata; bz = rf_20.busy; wr = rf_20.wr_ready; cd = rf_20.clr_done; end
        endcase
        case (s)
            2'd0:    return (p != 0) ? rd[63:32] : rd[31:0];
            2'd1:    return {31'b0, bz};
            2'd2:    return {31'b0, wr};
            default: return {31'b0, cd};
        endcase
    endfunction

    always @(negedge clk) begin : monitor
        exp_t        e;
        string       nm;
        logic [31:0] a;
        while (q.size() > 0) begin
            e  = q.pop_front();
            nm = qn.pop_front();
            a  = sample(e.d, e.s, e.p);
            n_chk++;
            if (a !== e.v)
                $display("FAIL %s: got %h expected %h", nm, a, e.v);
            else
                n_pass++;
        end
    end

    task automatic chk(input int d, input int s, input int p, input logic [31:0] v,
                       input string nm);
        exp_t e;
        e.d = 2'(d); e.s = 2'(s); e.p = 2'(p); e.v = v;
        q.push_back(e);
        qn.push_back(nm);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        rf.wr_en = 1'b0;    rf.clr_req = 1'b0;
        rf_nb.wr_en = 1'b0; rf_nb.clr_req = 1'b0;
        rf_20.wr_en = 1'b0; rf_20.clr_req = 1'b0;
    endtask

    task automatic rd0(input int a0, input int a1);
        rf.raddr = {5'(a1), 5'(a0)};
    endtask

    task automatic wr0(input int a, input logic [31:0] v);
        rf.wr_en = 1'b1; rf.waddr = 5'(a); rf.wdata = v;
    endtask

    initial begin
        quiet();
        rf.waddr = '0;    rf.wdata = '0;    rf.raddr = '0;
        rf_nb.waddr = '0; rf_nb.wdata = '0; rf_nb.raddr = '0;
        rf_20.waddr = '0; rf_20.wdata = '0; rf_20.raddr = '0;
        #1 rst_n = 1'b0;
        rd0(5, 3);
        chk(0, 1, 0, 0, "rst_busy");
        chk(0, 2, 0, 1, "rst_wr_ready");
        chk(0, 3, 0, 0, "rst_clr_done");
        chk(0, 0, 0, 0, "rst_rdata0");
        chk(0, 0, 1, 0, "rst_rdata1");
        step(); step();
        rst_n = 1'b1;
        chk(0, 2, 0, 1, "post_rst_wr_ready");
        chk(0, 0, 0, 0, "post_rst_rdata0");
        step();

        // Write r5; preload r7 on the no-bypass instance
        wr0(5, 32'hDEADBEEF);
        rf_nb.wr_en = 1'b1; rf_nb.waddr = 5'd7; rf_nb.wdata = 32'h11110000;
        step(); quiet();
        rd0(5, 5);
        chk(0, 0, 0, 32'hDEADBEEF, "r5_port0");
        chk(0, 0, 1, 32'hDEADBEEF, "r5_port1");
        step();

        // Same-cycle write/read of r7
        wr0(7, 32'h12345678);
        rd0(5, 7);
        chk(0, 0, 1, 32'h12345678, "bypass_r7");
        chk(0, 0, 0, 32'hDEADBEEF, "r5_during_write");
        rf_nb.wr_en = 1'b1; rf_nb.waddr = 5'd7; rf_nb.wdata = 32'h12345678;
        rf_nb.raddr = {5'd7, 5'd7};
        chk(1, 0, 1, 32'h11110000, "nobypass_old");
        step(); quiet();

        // Write to r0 must be ignored, including bypass
        wr0(0, 32'hFFFFFFFF);
        rd0(0, 0);
        chk(0, 0, 0, 0, "r0_bypass_p0");
        chk(0, 0, 1, 0, "r0_bypass_p1");
        chk(1, 0, 1, 32'h12345678, "nobypass_new");
        step(); quiet();
        chk(0, 0, 0, 0, "r0_after_p0");
        chk(0, 0, 1, 0, "r0_after_p1");
        step();

        for (int i = 1; i < 32; i++) begin
            wr0(i, 32'(i));
            step();
        end
        quiet();
        rd0(1, 31);
        chk(0, 0, 0, 1,  "fill_r1");
        chk(0, 0, 1, 31, "fill_r31");
        rf.clr_req = 1'b1;
        chk(0, 1, 0, 0, "pre_sweep_busy");
        step();

        for (int i = 0; i < 32; i++) begin
            quiet();
            rd0((i >= 1) ? i - 1 : 0, 31);
            if (i == 5)  rf.clr_req = 1'b1;
            if (i == 20) wr0(9, 32'h99);
            chk(0, 1, 0, 1, "sweep_busy");
            chk(0, 2, 0, 0, "sweep_wr_ready");
            chk(0, 3, 0, (i == 31) ? 1 : 0, "sweep_clr_done");
            chk(0, 0, 1, 31, "sweep_unswept_r31");
            if (i >= 1) chk(0, 0, 0, 0, "sweep_swept_reg");
            step();
        end
        quiet();
        chk(0, 1, 0, 0, "post_sweep_busy");
        chk(0, 3, 0, 0, "post_sweep_clr_done");
        chk(0, 2, 0, 1, "post_sweep_wr_ready");
        for (int j = 0; j < 16; j++) begin
            rd0(2 * j, 2 * j + 1);
            chk(0, 0, 0, 0, "cleared_even");
            chk(0, 0, 1, 0, "cleared_odd");
            step();
        end

        // Write and clear request in the same idle cycle
        wr0(3, 32'hA5A5A5A5);
        rf.clr_req = 1'b1;
        step(); quiet();
        rd0(3, 3);
        chk(0, 0, 0, 32'hA5A5A5A5, "r3_wr_with_clr");
        chk(0, 1, 0, 1, "r3_sweep_busy");
        step();
        for (int i = 1; i < 32; i++) step();
        chk(0, 1, 0, 0, "r3_sweep_end_busy");
        chk(0, 0, 0, 0, "r3_swept");
        step();

        // Reset in the middle of a sweep
        wr0(30, 32'h30);
        step();
        wr0(4, 32'h44);
        step(); quiet();
        rf.clr_req = 1'b1;
        step(); quiet();
        for (int i = 0; i < 10; i++) step();
        rd0(4, 30);
        chk(0, 1, 0, 1, "pre_abort_busy");
        step();
        rst_n = 1'b0;
        chk(0, 1, 0, 0, "abort_busy");
        chk(0, 3, 0, 0, "abort_clr_done");
        chk(0, 2, 0, 1, "abort_wr_ready");
        chk(0, 0, 0, 0, "abort_r4");
        chk(0, 0, 1, 0, "abort_r30");
        step();
        rst_n = 1'b1;
        chk(0, 1, 0, 0, "released_busy");
        chk(0, 0, 1, 0, "released_r30");
        wr0(12, 32'h1212);
        step(); quiet();
        rd0(12, 30);
        chk(0, 0, 0, 32'h1212, "released_write");
        chk(0, 1, 0, 0, "released_idle");
        step();

        // Out-of-range address on the 20-register build
        rf_20.wr_en = 1'b1; rf_20.waddr = 5'd25; rf_20.wdata = 32'hCAFE;
        rf_20.raddr = {5'd25, 5'd25};
        chk(2, 0, 0, 0, "oor_bypass_p0");
        chk(2, 0, 1, 0, "oor_bypass_p1");
        step(); quiet();
        rf_20.wr_en = 1'b1; rf_20.waddr = 5'd19; rf_20.wdata = 32'h19191919;
        rf_20.raddr = {5'd25, 5'd19};
        chk(2, 0, 0, 32'h19191919, "top_reg_bypass");
        chk(2, 0, 1, 0, "oor_after_write");
        step(); quiet();
        chk(2, 0, 0, 32'h19191919, "top_reg_stored");
        chk(2, 0, 1, 0, "oor_stored");
        step(); step();

        if (q.size() != 0) begin
            n_chk++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter XLEN, default 32, data word width in bits.
REQ-002 Parameter NREGS, default 32, number of registers; legal range 2..256.
REQ-003 Parameter NRD, default 2, number of independent read ports; legal range 1..4.
REQ-004 Parameter ZERO_REG, default 1, when 1 register 0 reads as zero and ignores writes.
REQ-005 Parameter BYPASS, default 1, when 1 a same-cycle write is forwarded to matching read ports.
REQ-006 Derived AW = max(1, clog2(NREGS)) address width.
REQ-007 clk  input  1  single clock; all state updates on rising edge.
REQ-008 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-009 raddr  input  NRD*AW  read addresses; port k occupies bits [k*AW +: AW].
REQ-010 rdata  output  NRD*XLEN  read data; port k occupies bits [k*XLEN +: XLEN].
REQ-011 wr_en  input  1  write request.
REQ-012 waddr  input  AW  write address.
REQ-013 wdata  input  XLEN  write data.
REQ-014 wr_ready  output  1  write accepted this cycle when high.
REQ-015 clr_req  input  1  request sweep-clear of all registers.
REQ-016 busy  output  1  clear sweep in progress.
REQ-017 clr_done  output  1  one-cycle pulse on final sweep cycle.

Function
REQ-018 Write commit (wr_fire) = wr_en & wr_ready & waddr < NREGS & !(ZERO_REG & waddr==0); array updated at rising clk.
REQ-019 Reads are combinational, zero-latency, per port: ZERO_REG & addr==0 -> 0; addr >= NREGS -> 0; BYPASS & wr_fire & waddr==addr -> wdata; else stored value.
REQ-020 With BYPASS=0, read of the address being written returns the old value until after the edge.
REQ-021 All NRD ports are independent; identical addresses on several ports return identical data.
REQ-022 FSM states IDLE and CLEAR; IDLE & clr_req -> CLEAR with index=0 at next edge.
REQ-023 In CLEAR, each edge writes 0 to register[index] and increments index; index==NREGS-1 -> IDLE.
REQ-024 busy = 1 exactly while in CLEAR, i.e. NREGS consecutive cycles per sweep.
REQ-025 clr_done = 1 only in the CLEAR cycle with index==NREGS-1.
REQ-026 wr_ready = !busy; wr_en while busy is dropped, not queued.
REQ-027 clr_req while in CLEAR is ignored; no restart, no extension.
REQ-028 wr_en and clr_req together in IDLE: write commits that edge, sweep begins next cycle and later zeroes it.
REQ-029 Reads during CLEAR return current array content (already-swept registers read 0); no bypass applies.
REQ-030 Index register width AW; no wrap beyond NREGS-1.

Reset
REQ-031 rst_n low asynchronously zeroes all registers, forces IDLE, index=0, busy=0, clr_done=0.
REQ-032 wr_ready = 1 and all rdata = 0 while and immediately after reset.
REQ-033 rst_n asserted mid-sweep aborts it; after release FSM is IDLE with all registers zero.
REQ-034 Reset release is synchronised externally; block needs no further init cycles.

Verification
REQ-035 Write 0xDEADBEEF to r5, read r5 on both ports next cycle -> both rdata = 0xDEADBEEF.
REQ-036 BYPASS=1: write 0x12345678 to r7 while port 1 reads r7 same cycle -> rdata1 = 0x12345678 combinationally; BYPASS=0 -> old value.
REQ-037 Write 0xFFFFFFFF to r0 (ZERO_REG=1) -> r0 reads 0 on every port.
REQ-038 Fill r1..r31 with index value, pulse clr_req -> busy high exactly 32 cycles, clr_done on 32nd, wr_ready low throughout, all regs read 0 after.
REQ-039 wr_en with clr_req in same IDLE cycle (r3=0xA5A5A5A5) -> r3 reads 0xA5A5A5A5 one cycle, 0 after sweep.
REQ-040 Assert rst_n low at sweep cycle 10 -> busy=0, clr_done=0 immediately; all regs 0 after release; NREGS=20 build: addr 25 reads 0, write to 25 ignored.
